// File: rtl/cordic_hyp_iter_pkg.sv
// Shared constants, FSM state type and helpers for the hyperbolic CORDIC iteration core.
package cordic_hyp_iter_pkg;

    localparam int unsigned IDWIDTH     = 32;
    localparam int unsigned I_FRA_WIDTH = 28;

    // Shift indices executed twice so the hyperbolic sequence converges.
    localparam int unsigned NREP              = 2;
    localparam int unsigned REP_IDX [NREP]    = '{4, 13};

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    function automatic int unsigned num_steps(input int unsigned n_iter);
        int unsigned n;
        n = n_iter;
        for (int k = 0; k < NREP; k++) begin
            if (REP_IDX[k] <= n_iter) n++;
        end
        return n;
    endfunction

    // atanh(2^-i) * 2^fra, rounded; Taylor series accumulated in Q60 (fra must be < 60).
    function automatic logic [63:0] atanh_fixed(input int unsigned i, input int unsigned fra);
        logic [63:0] acc;
        int unsigned e;
        acc = '0;
        for (int k = 0; k < 30; k++) begin
            e = i * (2 * k + 1);
            if (e <= 60) acc = acc + ((64'd1 << (60 - e)) / 64'(2 * k + 1));
        end
        return (acc + (64'd1 << (59 - fra))) >> (60 - fra);
    endfunction

endpackage

// File: rtl/atanh_rom.sv
// Combinational table of atanh(2^-i) constants, indexed by the current shift index.
module atanh_rom
    import cordic_hyp_iter_pkg::*;
#(
    parameter int unsigned DWIDTH    = IDWIDTH,
    parameter int unsigned FRA_WIDTH = I_FRA_WIDTH,
    parameter int unsigned N_ITER    = 16,
    parameter int unsigned IW        = $clog2(DWIDTH)
) (
    input  logic [IW-1:0]     idx_i,
    output logic [DWIDTH-1:0] atanh_o
);

    logic [DWIDTH-1:0] rom [2**IW];

    for (genvar g = 0; g < 2**IW; g++) begin : g_rom
        if (g >= 1 && g <= N_ITER) begin : g_ent
            assign rom[g] = DWIDTH'(atanh_fixed(g, FRA_WIDTH));
        end else begin : g_zero
            assign rom[g] = '0;
        end
    end

    assign atanh_o = rom[idx_i];

endmodule

// File: rtl/cordic_hyp_iter.sv
// Iterative hyperbolic CORDIC rotation: one micro-rotation per cycle, valid/ready handshake.
module cordic_hyp_iter
    import cordic_hyp_iter_pkg::*;
#(
    parameter int unsigned DWIDTH    = IDWIDTH,
    parameter int unsigned FRA_WIDTH = I_FRA_WIDTH,
    parameter int unsigned N_ITER    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] Xin,
    input  logic signed [DWIDTH-1:0] Yin,
    input  logic signed [DWIDTH-1:0] Zin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DWIDTH-1:0] Xout,
    output logic signed [DWIDTH-1:0] Yout,
    output logic signed [DWIDTH-1:0] Zout,
    output logic                     busy
);

    localparam int unsigned NSTEP = num_steps(N_ITER);
    localparam int unsigned SW    = $clog2(NSTEP);
    localparam int unsigned IW    = $clog2(DWIDTH);

    state_e                   state_q, state_d;
    logic [SW-1:0]            step_q, step_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     rep_q, rep_d;
    logic signed [DWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [DWIDTH-1:0] atanh_val, xs, ys;
    logic                     rep_hit, last_step;

    atanh_rom #(
        .DWIDTH    (DWIDTH),
        .FRA_WIDTH (FRA_WIDTH),
        .N_ITER    (N_ITER),
        .IW        (IW)
    ) u_rom (
        .idx_i   (idx_q),
        .atanh_o (atanh_val)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        xs        = x_q >>> idx_q;
        ys        = y_q >>> idx_q;
        last_step = (step_q == SW'(NSTEP - 1));
        rep_hit   = 1'b0;
        for (int k = 0; k < NREP; k++) begin
            if (32'(idx_q) == REP_IDX[k]) rep_hit = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = Xin;
                    y_d     = Yin;
                    z_d     = Zin;
                    step_d  = '0;
                    idx_d   = IW'(1);
                    rep_d   = 1'b0;
                    state_d = StIter;
                end
            end
            StIter: begin
                if (z_q[DWIDTH-1]) begin
                    x_d = x_q - ys;
                    y_d = y_q - xs;
                    z_d = z_q + atanh_val;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q + xs;
                    z_d = z_q - atanh_val;
                end
                // A repeat index is issued twice before the index advances.
                if (rep_hit && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    rep_d = 1'b0;
                end
                if (last_step) begin
                    state_d = StDone;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            idx_q   <= '0;
            rep_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StIter);
    assign Xout      = x_q;
    assign Yout      = y_q;
    assign Zout      = z_q;

endmodule
